// File: rtl/gen_proto_pkg.sv
// Shared definitions for generator-protocol blocks: caller FSM states and
// the default data width.
package gen_proto_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4
  } gen_state_e;

endpackage

// File: rtl/gen_ready_throttle.sv
// Backpressure pattern generator: ready is high one cycle in every THROTTLE+1
// while enabled, and the first enabled cycle after a restart is always ready.
module gen_ready_throttle #(
  parameter int THROTTLE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic ready
);

  localparam int CW = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(THROTTLE);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ready = enable && (cnt_q == '0);

endmodule

// File: rtl/hrange_sum_caller.sv
// Caller-side generator block: launches a child range generator, sums and
// counts its yields, then yields the single (sum, count) tuple upward.
module hrange_sum_caller
  import gen_proto_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int THROTTLE = 0
) (
  input  logic              _clock,
  input  logic              _reset_n,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] limit,
  input  logic [DATA_W-1:0] step,
  input  logic              _start,
  input  logic              _ready,
  output logic              _valid,
  output logic              _done,
  output logic [DATA_W-1:0] _0,
  output logic [DATA_W-1:0] _1,
  output logic              _inner_start,
  output logic [DATA_W-1:0] _inner_base,
  output logic [DATA_W-1:0] _inner_limit,
  output logic [DATA_W-1:0] _inner_step,
  output logic              _inner_ready,
  input  logic              _inner_valid,
  input  logic [DATA_W-1:0] _inner_0,
  input  logic              _inner_done,
  output logic [2:0]        dbg_state
);

  // Handshakes (both sides): a transfer happens at a clock edge where valid
  // and ready are both high; valid holds its data stable until that edge.

  gen_state_e        state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] limit_q, limit_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;

  logic drain_en;
  logic launch;
  logic xfer;

  assign drain_en = (state_q == ST_DRAIN);
  assign launch   = (state_q == ST_LAUNCH);
  assign xfer     = drain_en && _inner_valid && _inner_ready;

  gen_ready_throttle #(
    .THROTTLE (THROTTLE)
  ) u_throttle (
    .clk     (_clock),
    .rst_n   (_reset_n),
    .enable  (drain_en),
    .restart (launch),
    .ready   (_inner_ready)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    limit_d = limit_q;
    step_d  = step_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    // A new start aborts whatever is in flight, including a pending result.
    if (_start) begin
      state_d = ST_LAUNCH;
      base_d  = base;
      limit_d = limit;
      step_d  = step;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_LAUNCH: state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (xfer) begin
            acc_d = acc_q + _inner_0;
            cnt_d = cnt_q + DATA_W'(1);
          end
          if (_inner_done) begin
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (_ready) begin
            state_d = ST_FINISH;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign _valid       = (state_q == ST_EMIT);
  assign _done        = (state_q == ST_FINISH);
  assign _inner_start = launch;
  assign _inner_base  = base_q;
  assign _inner_limit = limit_q;
  assign _inner_step  = step_q;
  assign _0           = acc_q;
  assign _1           = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hrange_sum_caller.sv
// Bench for hrange_sum_caller: two instances (THROTTLE 0 and 2) share the
// caller-side stimulus, each driven by its own behavioural hrange child.
module tb_hrange_sum_caller;
  import gen_proto_pkg::*;

  localparam int W = 32;
  localparam int THR0 = 0;
  localparam int THR1 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_base = '0, a_limit = '0, a_step = '0;
  logic         start = 1'b0;
  logic         rdy = 1'b1;

  logic [1:0]   valid, done, istart, iready, ivalid, idone;
  logic [W-1:0] o0 [2];
  logic [W-1:0] o1 [2];
  logic [W-1:0] ib [2];
  logic [W-1:0] il [2];
  logic [W-1:0] is [2];
  logic [W-1:0] i0 [2];
  logic [2:0]   st [2];

  hrange_sum_caller #(.DATA_W(W), .THROTTLE(THR0)) u_dut0 (
    ._clock(clk), ._reset_n(rst_n), .base(a_base), .limit(a_limit), .step(a_step),
    ._start(start), ._ready(rdy), ._valid(valid[0]), ._done(done[0]),
    ._0(o0[0]), ._1(o1[0]), ._inner_start(istart[0]), ._inner_base(ib[0]),
    ._inner_limit(il[0]), ._inner_step(is[0]), ._inner_ready(iready[0]),
    ._inner_valid(ivalid[0]), ._inner_0(i0[0]), ._inner_done(idone[0]),
    .dbg_state(st[0])
  );

  hrange_sum_caller #(.DATA_W(W), .THROTTLE(THR1)) u_dut1 (
    ._clock(clk), ._reset_n(rst_n), .base(a_base), .limit(a_limit), .step(a_step),
    ._start(start), ._ready(rdy), ._valid(valid[1]), ._done(done[1]),
    ._0(o0[1]), ._1(o1[1]), ._inner_start(istart[1]), ._inner_base(ib[1]),
    ._inner_limit(il[1]), ._inner_step(is[1]), ._inner_ready(iready[1]),
    ._inner_valid(ivalid[1]), ._inner_0(i0[1]), ._inner_done(idone[1]),
    .dbg_state(st[1])
  );

  // ---------------- behavioural hrange children ----------------
  longint c_cur [2];
  longint c_lim [2];
  longint c_stp [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ivalid[i] <= 1'b0;
        idone[i]  <= 1'b0;
        i0[i]     <= '0;
        c_cur[i]  <= 0;
        c_lim[i]  <= 0;
        c_stp[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        longint b, l, s, nxt;
        idone[i] <= 1'b0;
        if (istart[i]) begin
          b = longint'($signed(ib[i]));
          l = longint'($signed(il[i]));
          s = longint'($signed(is[i]));
          c_cur[i]  <= b;
          c_lim[i]  <= l;
          c_stp[i]  <= s;
          i0[i]     <= ib[i];
          ivalid[i] <= (b < l);
          idone[i]  <= !(b < l);
        end else if (ivalid[i] && iready[i]) begin
          nxt = c_cur[i] + c_stp[i];
          c_cur[i] <= nxt;
          if (nxt < c_lim[i]) begin
            i0[i] <= nxt[W-1:0];
          end else begin
            ivalid[i] <= 1'b0;
            idone[i]  <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] b, input logic [W-1:0] l,
                                        input logic [W-1:0] s);
    longint cur = longint'($signed(b));
    longint lim = longint'($signed(l));
    longint stp = longint'($signed(s));
    logic [W-1:0] sum = '0;
    logic [W-1:0] cnt = '0;
    int guard = 0;
    while (cur < lim && guard < 10000) begin
      sum = sum + cur[W-1:0];
      cnt = cnt + 1;
      cur = cur + stp;
      guard++;
    end
    return {sum, cnt};
  endfunction

  // ---------------- scoreboard and protocol monitors ----------------
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [1:0]  hs_prev = '0;
  logic [1:0]  idone_prev = '0;
  logic [2:0]  st_prev [2] = '{3'd0, 3'd0};
  int          thr_idx [2] = '{0, 0};
  int          done_seen [2] = '{0, 0};
  int          xfer0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev    = '0;
      idone_prev = '0;
      st_prev    = '{3'd0, 3'd0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        int thr;
        logic [63:0] e;
        thr = (i == 0) ? THR0 : THR1;
        if (valid[i] && rdy) begin
          if (i == 0 && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("result0", {o0[i], o1[i]}, e);
          end else if (i == 1 && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("result1", {o0[i], o1[i]}, e);
          end else begin
            check("unexpected_result", 64'd1, 64'd0);
          end
        end
        if (hs_prev[i] || done[i]) check("done_after_hs", done[i], hs_prev[i]);
        if (done[i]) check("done_without_valid", valid[i], 1'b0);
        if (idone_prev[i] && st_prev[i] == ST_DRAIN) check("valid_after_inner_done", valid[i], 1'b1);
        if (st[i] == ST_DRAIN) begin
          thr_idx[i] = (st_prev[i] == ST_DRAIN) ? thr_idx[i] + 1 : 0;
          check("inner_ready_pattern", iready[i], (thr_idx[i] % (thr + 1)) == 0);
        end else begin
          check("inner_ready_off", iready[i], 1'b0);
        end
        if (done[i]) done_seen[i]++;
        hs_prev[i]    = valid[i] && rdy;
        idone_prev[i] = idone[i];
        st_prev[i]    = st[i];
      end
      if (ivalid[0] && iready[0]) xfer0++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [W-1:0] b, input logic [W-1:0] l,
                           input logic [W-1:0] s, input bit push);
    @(posedge clk); #1;
    a_base = b; a_limit = l; a_step = s; start = 1'b1;
    if (push) begin
      exp_q0.push_back(model(b, l, s));
      exp_q1.push_back(model(b, l, s));
    end
    @(posedge clk); #1;
    start = 1'b0;
    a_base = W'($urandom); a_limit = W'($urandom); a_step = W'($urandom);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("inner_start_launch", istart[i], 1'b1);
      check("inner_args", {ib[i], il[i]}, {b, l});
      check("inner_step", is[i], s);
      check("launch_no_valid", valid[i], 1'b0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("inner_start_drop", istart[i], 1'b0);
      check("drain_entry", st[i], ST_DRAIN);
    end
  endtask

  task automatic wait_done(input int t0, input int t1);
    int cyc = 0;
    while ((done_seen[0] < t0 || done_seen[1] < t1) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("run_timeout", cyc < 3000, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check(tag, {valid[i], done[i], istart[i], iready[i], st[i]}, 64'd0);
      check(tag, {o0[i], o1[i]}, 64'd0);
      check(tag, {ib[i], il[i]}, 64'd0);
      check(tag, is[i], 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, d1, cyc;
    #2;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain run, then an empty range.
    start_run(32'd0, 32'd10, 32'd2, 1'b1);
    wait_done(1, 1);
    start_run(32'd5, 32'd5, 32'd1, 1'b1);
    wait_done(2, 2);

    // Random small ranges, including negative bases.
    for (int k = 0; k < 4; k++) begin
      start_run(W'($signed($urandom_range(0, 40)) - 20), W'($urandom_range(0, 30)),
                W'($urandom_range(1, 5)), 1'b1);
      wait_done(3 + k, 3 + k);
    end

    // Upstream backpressure: result must hold for 10 cycles.
    @(posedge clk); #1 rdy = 1'b0;
    d0 = done_seen[0]; d1 = done_seen[1];
    start_run(32'd0, 32'd10, 32'd2, 1'b1);
    cyc = 0;
    while (!valid[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("valid_rise_timeout", cyc < 200, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", valid[0], 1'b1);
      check("hold_result", {o0[0], o1[0]}, {32'd20, 32'd5});
      check("hold_no_done", done[0], 1'b0);
      if (k < 9) @(negedge clk);
    end
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(d0 + 1, d1 + 1);

    // Abort after two child transfers; only the restarted run completes.
    d0 = done_seen[0]; d1 = done_seen[1];
    xfer0 = 0;
    start_run(32'd0, 32'd100, 32'd1, 1'b0);
    cyc = 0;
    while (xfer0 < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_xfer_timeout", cyc < 200, 1'b1);
    start_run(32'd1, 32'd4, 32'd1, 1'b1);
    wait_done(d0 + 1, d1 + 1);
    repeat (5) @(negedge clk);
    check("abort_single_done0", done_seen[0], d0 + 1);
    check("abort_single_done1", done_seen[1], d1 + 1);

    // Asynchronous reset in the middle of DRAIN, between clock edges.
    start_run(32'd0, 32'd100, 32'd1, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_drain", st[0], ST_DRAIN);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Wrapping sum with a child that stops at signed overflow.
    start_run(32'h4000_0000, 32'h7FFF_FFFF, 32'h2000_0000, 1'b1);
    wait_done(done_seen[0] + 1, done_seen[1] + 1);
    check("wrap_model", model(32'h4000_0000, 32'h7FFF_FFFF, 32'h2000_0000),
          {32'hA000_0000, 32'd2});

    repeat (3) @(negedge clk);
    check("scoreboard_drained0", exp_q0.size(), 0);
    check("scoreboard_drained1", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
